// File: rtl/letreiro_controlador_pkg.sv
`default_nettype none
// ============================================================================
// letreiro_controlador_pkg : shared types and constants for the scrolling sign
// Revision: 1.0
// ============================================================================
package letreiro_controlador_pkg;

   localparam int N_DISP = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCROLL = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      LTR_I = 3'b000,
      LTR_E = 3'b001,
      LTR_L = 3'b010,
      SPACE = 3'b011,
      LTR_G = 3'b100,
      LTR_A = 3'b101,
      LTR_B = 3'b110,
      LTR_R = 3'b111
   } letter_t;

   // (base + k) mod (lenm1 + 1) without a divider; base < L so three folds suffice
   function automatic logic [3:0] disp_index(input logic [3:0] base,
                                             input logic [1:0] k,
                                             input logic [3:0] lenm1);
      logic [4:0] s;
      logic [4:0] l;
      l = {1'b0, lenm1} + 5'd1;
      s = {1'b0, base} + {3'b000, k};
      for (int i = 0; i < 3; i++) begin
         if (s >= l) s = s - l;
      end
      return s[3:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/letreiro_controlador_if.sv
`default_nettype none
// ============================================================================
// letreiro_controlador_if : control, message-write and display bus of the sign
// Revision: 1.0
// ============================================================================
interface letreiro_controlador_if;
   import letreiro_controlador_pkg::*;

   logic                  start;
   logic                  stop;
   logic                  hold;
   logic                  dir;
   logic [3:0]            len_in;
   logic                  wr_en;
   logic [3:0]            wr_addr;
   logic [2:0]            wr_data;
   logic [3*N_DISP-1:0]   codigos;
   logic [3:0]            pos;
   logic                  busy;
   logic                  volta;

   modport master (
      output start, stop, hold, dir, len_in, wr_en, wr_addr, wr_data,
      input  codigos, pos, busy, volta
   );

   modport slave (
      input  start, stop, hold, dir, len_in, wr_en, wr_addr, wr_data,
      output codigos, pos, busy, volta
   );

endinterface
`default_nettype wire

// File: rtl/letreiro_controlador_divisor_tick.sv
`default_nettype none
// ============================================================================
// divisor_tick : scroll-rate prescaler, one-cycle tick every DIV_MAX enabled cycles
// Revision: 1.0
// ============================================================================
module divisor_tick #(
   parameter int DIV_MAX = 50000000
) (
   input  wire logic clk,
   input  wire logic reset,
   input  wire logic en_i,
   input  wire logic clr_i,
   output logic      tick_o
);

   localparam int CW = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV_MAX - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick_o = en_i && (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = tick_o ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule
`default_nettype wire

// File: rtl/letreiro_controlador.sv
`default_nettype none
// ============================================================================
// letreiro_controlador : scrolls a 1..16 letter message across four 7-seg displays
// Revision: 1.0
// ============================================================================
module letreiro_controlador #(
   parameter int DIV_MAX = 50000000,
   parameter int N_DISP  = 4
) (
   input  wire logic               clk,
   input  wire logic               reset,
   letreiro_controlador_if.slave   bus
);
   import letreiro_controlador_pkg::*;

   state_t      state_q, state_d;
   logic [3:0]  pos_q, pos_d;
   logic [3:0]  lenm1_q, lenm1_d;
   logic        volta_q, volta_d;
   logic [2:0]  mem_q [16];
   logic        tick;
   logic        presc_en;
   logic        presc_clr;
   logic        wrap;
   logic [3:0]  pos_step;
   logic [3*N_DISP-1:0] codigos_w;

   // stop wins over a pending tick, so it also masks the prescaler enable
   assign presc_en  = (state_q == ST_SCROLL) && !bus.hold && !bus.stop;
   assign presc_clr = (state_q == ST_IDLE) || bus.stop;

   divisor_tick #(
      .DIV_MAX (DIV_MAX)
   ) u_divisor_tick (
      .clk    (clk),
      .reset  (reset),
      .en_i   (presc_en),
      .clr_i  (presc_clr),
      .tick_o (tick)
   );

   always_comb begin
      if (bus.dir) begin
         wrap     = (pos_q == 4'd0);
         pos_step = wrap ? lenm1_q : pos_q - 4'd1;
      end else begin
         wrap     = (pos_q == lenm1_q);
         pos_step = wrap ? 4'd0 : pos_q + 4'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      lenm1_d = lenm1_q;
      volta_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            pos_d = 4'd0;
            if (bus.start) begin
               state_d = ST_SCROLL;
               lenm1_d = bus.len_in;
            end
         end
         ST_SCROLL: begin
            if (bus.hold) begin
               state_d = ST_HOLD;
            end else if (tick) begin
               pos_d   = pos_step;
               volta_d = wrap;
            end
         end
         ST_HOLD: begin
            if (!bus.hold) state_d = ST_SCROLL;
         end
         default: state_d = ST_IDLE;
      endcase
      if (bus.stop) begin
         state_d = ST_IDLE;
         pos_d   = 4'd0;
         volta_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         pos_q   <= 4'd0;
         lenm1_q <= 4'd0;
         volta_q <= 1'b0;
         for (int i = 0; i < 16; i++) mem_q[i] <= SPACE;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         lenm1_q <= lenm1_d;
         volta_q <= volta_d;
         if (bus.wr_en) mem_q[bus.wr_addr] <= bus.wr_data;
      end
   end

   for (genvar k = 0; k < N_DISP; k++) begin : g_disp
      assign codigos_w[3*k +: 3] = (state_q == ST_IDLE) ? SPACE
                                 : mem_q[disp_index(pos_q, 2'(k), lenm1_q)];
   end

   assign bus.codigos = codigos_w;
   assign bus.pos     = pos_q;
   assign bus.busy    = (state_q != ST_IDLE);
   assign bus.volta   = volta_q;

endmodule
`default_nettype wire

// File: tb/tb_letreiro_controlador.sv
`default_nettype none
// ============================================================================
// tb_letreiro_controlador : directed scenarios plus random traffic vs a rule model
// Revision: 1.0
// ============================================================================
module tb_letreiro_controlador;

   localparam int DIV = 4;
   localparam int M_IDLE = 0, M_SCROLL = 1, M_HOLD = 2;

   logic clk = 1'b0;
   logic reset;

   letreiro_controlador_if bus();

   letreiro_controlador #(.DIV_MAX(DIV), .N_DISP(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int   n_chk  = 0;
   int   n_fail = 0;
   int   m_mode, m_pos, m_presc, m_len;
   logic m_volta;
   int   m_mem [16];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [11:0] exp_codigos();
      logic [11:0] c;
      for (int k = 0; k < 4; k++)
         c[3*k +: 3] = (m_mode == M_IDLE) ? 3'b011 : 3'(m_mem[(m_pos + k) % m_len]);
      return c;
   endfunction

   // Rule-level reference: applies one clock edge using the inputs present before it
   task automatic model_edge();
      m_volta = 1'b0;
      if (reset) begin
         m_mode = M_IDLE; m_pos = 0; m_presc = 0; m_len = 1;
         for (int i = 0; i < 16; i++) m_mem[i] = 3;
         return;
      end
      if (bus.wr_en) m_mem[bus.wr_addr] = int'(bus.wr_data);
      if (bus.stop) begin
         m_mode = M_IDLE; m_pos = 0; m_presc = 0;
      end else if (m_mode == M_IDLE) begin
         m_pos = 0; m_presc = 0;
         if (bus.start) begin m_mode = M_SCROLL; m_len = int'(bus.len_in) + 1; end
      end else if (m_mode == M_SCROLL) begin
         if (bus.hold) m_mode = M_HOLD;
         else if (m_presc == DIV - 1) begin
            m_presc = 0;
            if (bus.dir == 1'b0) begin
               m_volta = (m_pos == m_len - 1);
               m_pos   = (m_pos + 1) % m_len;
            end else begin
               m_volta = (m_pos == 0);
               m_pos   = (m_pos + m_len - 1) % m_len;
            end
         end else m_presc++;
      end else if (!bus.hold) m_mode = M_SCROLL;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("codigos", 32'(bus.codigos), 32'(exp_codigos()));
      chk("pos",     32'(bus.pos),     32'(m_pos));
      chk("busy",    32'(bus.busy),    32'(m_mode != M_IDLE));
      chk("volta",   32'(bus.volta),   32'(m_volta));
   endtask

   task automatic idle_inputs();
      bus.start = 0; bus.stop = 0; bus.hold = 0; bus.dir = 0;
      bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
   endtask

   initial begin
      int vcount;
      int n;
      int pos_saved;
      logic [2:0] gabriel [7];
      gabriel = '{3'b100, 3'b101, 3'b110, 3'b111, 3'b000, 3'b001, 3'b010};

      idle_inputs();
      bus.len_in = 0;
      reset = 1;
      step(); step();
      chk("reset_codigos", 32'(bus.codigos), 32'h6DB);
      chk("reset_busy", 32'(bus.busy), 0);
      reset = 0;

      for (int i = 0; i < 7; i++) begin
         bus.wr_en = 1; bus.wr_addr = 4'(i); bus.wr_data = gabriel[i];
         step();
      end
      bus.wr_en = 0;

      bus.len_in = 6; bus.start = 1;
      step();
      bus.start = 0; bus.len_in = 2;
      chk("gabr", 32'(bus.codigos), 32'({3'b111, 3'b110, 3'b101, 3'b100}));
      repeat (4) step();
      chk("abri", 32'(bus.codigos), 32'({3'b000, 3'b111, 3'b110, 3'b101}));
      chk("pos_after4", 32'(bus.pos), 1);

      vcount = 0;
      repeat (24) begin
         step();
         if (bus.volta) vcount++;
      end
      chk("volta_count", 32'(vcount), 1);
      chk("pos_wrapped", 32'(bus.pos), 0);

      bus.dir = 1;
      repeat (4) step();
      chk("dir1_pos", 32'(bus.pos), 6);
      chk("dir1_volta", 32'(bus.volta), 1);

      bus.dir = 0; bus.stop = 1;
      step();
      bus.stop = 0; bus.len_in = 1; bus.start = 1;
      step();
      bus.start = 0;
      chk("l2_pattern", 32'(bus.codigos), 32'({3'b101, 3'b100, 3'b101, 3'b100}));

      repeat (2) step();
      chk("presc_at2", 32'(m_presc), 2);
      pos_saved = int'(bus.pos);
      bus.hold = 1;
      repeat (10) step();
      chk("hold_pos", 32'(bus.pos), 32'(pos_saved));
      bus.hold = 0;
      repeat (2) step();
      chk("hold_resume_early", 32'(bus.pos), 32'(pos_saved));
      step();
      chk("hold_resume_tick", 32'(bus.pos), 32'((pos_saved + 1) % 2));

      n = 0;
      while (m_presc != DIV - 1 && n < 16) begin step(); n++; end
      chk("reach_tick", 32'(m_presc), DIV - 1);
      bus.stop = 1;
      step();
      chk("stop_tick_codigos", 32'(bus.codigos), 32'h6DB);
      chk("stop_tick_volta", 32'(bus.volta), 0);
      bus.start = 1;
      step();
      chk("start_stop_idle", 32'(bus.busy), 0);
      bus.stop = 0; bus.len_in = 6;
      step();
      bus.start = 0;
      n = 0;
      while (m_pos != 3 && n < 64) begin step(); n++; end
      chk("reach_pos3", 32'(bus.pos), 3);
      reset = 1;
      step();
      reset = 0;
      chk("rst_pos", 32'(bus.pos), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      bus.start = 1;
      step();
      bus.start = 0;
      chk("rst_mem", 32'(bus.codigos), 32'h6DB);

      for (int i = 0; i < 600; i++) begin
         reset       = ($urandom_range(0, 149) == 0);
         bus.stop    = ($urandom_range(0, 39) == 0);
         bus.start   = ($urandom_range(0, 3) == 0);
         bus.hold    = ($urandom_range(0, 5) == 0);
         bus.dir     = ($urandom_range(0, 7) == 0) ? ~bus.dir : bus.dir;
         bus.len_in  = 4'($urandom_range(0, 15));
         bus.wr_en   = ($urandom_range(0, 2) == 0);
         bus.wr_addr = 4'($urandom_range(0, 15));
         bus.wr_data = 3'($urandom_range(0, 7));
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
